// File: rtl/multi_mode_ping_pong_counter.sv
// Bounded counter with three count modes (ping-pong, up-wrap, down-wrap) and hold.
// Adds a programmable step, a synchronous load, and an INIT/RUN/FAULT state machine.
// at_bound and wrap are one-edge registered pulses. Every output comes from a register.
module multi_mode_ping_pong_counter #(
  parameter int WIDTH  = 4,
  parameter int STEP_W = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              flip,
  input  logic              load,
  input  logic [WIDTH-1:0]  load_val,
  input  logic [STEP_W-1:0] step,
  input  logic [1:0]        mode,
  input  logic [WIDTH-1:0]  max,
  input  logic [WIDTH-1:0]  min,
  output logic [WIDTH-1:0]  out,
  output logic              direction,
  output logic              at_bound,
  output logic              wrap,
  output logic              fault
);

  localparam int XW = WIDTH + 1;
  localparam logic [1:0] M_PP = 2'b00, M_UP = 2'b01, M_DN = 2'b10;

  typedef enum logic [1:0] {S_INIT, S_RUN, S_FAULT} state_t;

  state_t         state_q, state_d;
  logic [WIDTH-1:0] out_d, ld_clamp;
  logic           dir_d, ab_d, wrap_d, d_pp;

  // The arithmetic has one extra bit, so a sum such as out+s can exceed max without overflowing.
  logic [WIDTH:0] s_x, out_x, max_x, min_x, up_x, dn_x;
  logic           cfg_ok, lo_hit, out_oor;

  assign s_x      = (step == '0) ? XW'(1) : XW'(step);
  assign out_x    = XW'(out);
  assign max_x    = XW'(max);
  assign min_x    = XW'(min);
  assign up_x     = out_x + s_x;
  assign dn_x     = out_x - s_x;                 // only used when !lo_hit, so never negative
  assign lo_hit   = out_x < (min_x + s_x);       // a step down would pass below min
  assign cfg_ok   = max > min;
  assign out_oor  = (out < min) || (out > max);
  assign ld_clamp = (load_val < min) ? min : (load_val > max) ? max : load_val;
  assign fault    = (state_q == S_FAULT);

  // Next-state and next-value logic. The pulse outputs default to 0 on every edge.
  always_comb begin
    state_d = state_q;
    out_d   = out;
    dir_d   = direction;
    ab_d    = 1'b0;
    wrap_d  = 1'b0;
    d_pp    = direction;
    case (state_q)
      S_INIT: begin
        if (cfg_ok) begin
          out_d   = min;
          dir_d   = 1'b1;
          ab_d    = 1'b1;
          state_d = S_RUN;
        end else begin
          state_d = S_FAULT;
        end
      end
      S_FAULT: begin
        if (cfg_ok) state_d = S_INIT;
      end
      S_RUN: begin
        if (!cfg_ok) begin
          state_d = S_FAULT;
        end else if (load) begin
          out_d = ld_clamp;
          ab_d  = (ld_clamp == min) || (ld_clamp == max);
        end else if (out_oor) begin
          // The bounds moved underneath the count, so restart from the bottom.
          out_d = min;
          dir_d = 1'b1;
          ab_d  = 1'b1;
        end else if (enable) begin
          case (mode)
            M_PP: begin
              d_pp = flip ? ~direction : direction;
              if (out == max) d_pp = 1'b0;     // a bound overrides flip
              if (out == min) d_pp = 1'b1;
              if (d_pp) out_d = (up_x > max_x) ? max : up_x[WIDTH-1:0];
              else      out_d = lo_hit ? min : dn_x[WIDTH-1:0];
              dir_d = d_pp;
              ab_d  = (out_d == max) || (out_d == min);
            end
            M_UP: begin
              dir_d = 1'b1;
              if (up_x > max_x) begin
                out_d  = min;
                wrap_d = 1'b1;
                ab_d   = 1'b1;
              end else begin
                out_d = up_x[WIDTH-1:0];
                ab_d  = (up_x == max_x);
              end
            end
            M_DN: begin
              dir_d = 1'b0;
              if (lo_hit) begin
                out_d  = max;
                wrap_d = 1'b1;
                ab_d   = 1'b1;
              end else begin
                out_d = dn_x[WIDTH-1:0];
                ab_d  = (dn_x == min_x);
              end
            end
            default: ;                          // mode 11: hold
          endcase
        end
      end
      default: state_d = S_INIT;
    endcase
  end

  // State and output registers. The reset is asynchronous, so it acts mid-cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_INIT;
      out       <= '0;
      direction <= 1'b1;
      at_bound  <= 1'b0;
      wrap      <= 1'b0;
    end else begin
      state_q   <= state_d;
      out       <= out_d;
      direction <= dir_d;
      at_bound  <= ab_d;
      wrap      <= wrap_d;
    end
  end

endmodule

// File: tb/tb_multi_mode_ping_pong_counter.sv
// Bench for multi_mode_ping_pong_counter. It runs directed scenarios and then random
// stimulus. Every output is compared against an integer reference model on every edge.
module tb_multi_mode_ping_pong_counter;
  localparam int WIDTH = 4, STEP_W = 2;

  logic clk = 1'b0, rst_n = 1'b0, enable = 1'b0, flip = 1'b0, load = 1'b0;
  logic [WIDTH-1:0] load_val = '0, max = '0, min = '0;
  logic [STEP_W-1:0] step = '0;
  logic [1:0] mode = '0;
  logic [WIDTH-1:0] out;
  logic direction, at_bound, wrap, fault;

  int checks = 0, failures = 0;
  // Model state: 0 = init, 1 = run, 2 = fault.
  int m_st, m_out, m_dir, m_ab, m_wrap;

  always #5 clk = ~clk;

  multi_mode_ping_pong_counter #(.WIDTH(WIDTH), .STEP_W(STEP_W)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .flip(flip), .load(load),
    .load_val(load_val), .step(step), .mode(mode), .max(max), .min(min),
    .out(out), .direction(direction), .at_bound(at_bound), .wrap(wrap), .fault(fault)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_st = 0; m_out = 0; m_dir = 1; m_ab = 0; m_wrap = 0;
  endtask

  // Applies the rules to the inputs sampled at this edge, using plain integer arithmetic.
  task automatic model_edge();
    int s, mx, mn, o, v, n, d;
    s  = (step == 0) ? 1 : int'(step);
    mx = int'(max); mn = int'(min); o = m_out;
    m_ab = 0; m_wrap = 0;
    case (m_st)
      0: if (mx > mn) begin m_out = mn; m_dir = 1; m_ab = 1; m_st = 1; end
         else m_st = 2;
      2: if (mx > mn) m_st = 0;
      default: begin
        if (!(mx > mn)) m_st = 2;
        else if (load) begin
          v = int'(load_val);
          if (v < mn) v = mn;
          if (v > mx) v = mx;
          m_out = v; m_ab = (v == mn || v == mx);
        end else if (o < mn || o > mx) begin
          m_out = mn; m_dir = 1; m_ab = 1;
        end else if (enable && mode != 3) begin
          if (mode == 0) begin
            d = flip ? 1 - m_dir : m_dir;
            if (o == mx) d = 0;
            if (o == mn) d = 1;
            n = d ? ((o + s > mx) ? mx : o + s) : ((o - s < mn) ? mn : o - s);
            m_out = n; m_dir = d; m_ab = (n == mx || n == mn);
          end else if (mode == 1) begin
            m_dir = 1;
            if (o + s > mx) begin m_out = mn; m_wrap = 1; m_ab = 1; end
            else begin m_out = o + s; m_ab = (o + s == mx); end
          end else begin
            m_dir = 0;
            if (o - s < mn) begin m_out = mx; m_wrap = 1; m_ab = 1; end
            else begin m_out = o - s; m_ab = (o - s == mn); end
          end
        end
      end
    endcase
  endtask

  task automatic compare_all();
    chk("out", out, m_out);
    chk("direction", direction, m_dir);
    chk("at_bound", at_bound, m_ab);
    chk("wrap", wrap, m_wrap);
    chk("fault", fault, (m_st == 2) ? 1 : 0);
  endtask

  // Starts at a negedge and ends at the next negedge, so the caller drives inputs there.
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
    @(negedge clk);
  endtask

  // Asserts reset between edges and checks that it takes effect at once.
  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    m_reset();
    compare_all();
    chk("async_rst_out", out, 0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic cfg(input int mn, input int mx, input int st, input int md);
    min = WIDTH'(mn); max = WIDTH'(mx); step = STEP_W'(st); mode = md[1:0];
  endtask

  initial begin
    int tp1[8] = '{2, 3, 4, 5, 4, 3, 2, 3};
    int tp1d[8] = '{1, 1, 1, 1, 0, 0, 0, 1};
    int tp2[8] = '{0, 3, 6, 8, 5, 2, 0, 3};
    int tp3[8] = '{1, 3, 5, 1, 3, 1, 6, 4};
    int tp3w[8] = '{0, 0, 0, 1, 0, 0, 1, 0};
    int frz;
    m_reset();
    @(negedge clk);

    // Ping-pong with step 1 between 2 and 5.
    cfg(2, 5, 1, 0); enable = 1'b1;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("tp1_out", out, tp1[i]);
      chk("tp1_dir", direction, tp1d[i]);
    end

    // Ping-pong with step 3, clamped at 8 and at 0.
    cfg(0, 8, 3, 0);
    do_reset();
    for (int i = 0; i < 8; i++) begin tick(); chk("tp2_out", out, tp2[i]); end

    // Up-wrap, then down-wrap.
    cfg(1, 6, 2, 1);
    do_reset();
    for (int i = 0; i < 8; i++) begin
      if (i == 5) mode = 2'b10;
      tick();
      chk("tp3_out", out, tp3[i]);
      chk("tp3_wrap", wrap, tp3w[i]);
    end

    // Flip going up, flip at the lower bound, and hold.
    cfg(0, 9, 1, 0);
    do_reset();
    repeat (4) tick();                        // 0,1,2,3
    flip = 1'b1; tick(); flip = 1'b0;
    chk("flip_out", out, 2); chk("flip_dir", direction, 0);
    repeat (2) tick();                        // 1,0
    flip = 1'b1; tick(); flip = 1'b0;
    chk("flip_bound_out", out, 1); chk("flip_bound_dir", direction, 1);
    frz = int'(out);
    enable = 1'b0; repeat (5) tick(); chk("freeze_en", out, frz);
    enable = 1'b1; mode = 2'b11; repeat (5) tick(); chk("freeze_mode", out, frz);
    mode = 2'b00;

    // Loads: clamping, load while disabled, and load beating flip.
    load_val = 4'd12; load = 1'b1; tick();
    chk("load_clamp", out, 9); chk("load_ab", at_bound, 1);
    load_val = 4'd4; enable = 1'b0; tick(); chk("load_dis", out, 4);
    enable = 1'b1; load_val = 4'd6; flip = 1'b1; frz = int'(direction); tick();
    load = 1'b0; flip = 1'b0;
    chk("load_flip_out", out, 6); chk("load_flip_dir", direction, frz);

    // Fault entry and recovery, then a bound that drops below the current count.
    cfg(3, 7, 1, 0); tick();                  // 6 is within [3,7]
    max = 4'd3; tick(); chk("fault_set", fault, 1);
    max = 4'd7; tick(); tick(); chk("fault_rec_out", out, 3); chk("fault_clr", fault, 0);
    load_val = 4'd7; load = 1'b1; tick(); load = 1'b0;
    max = 4'd4; tick(); chk("bound_drop", out, 3);
    cfg(0, 9, 1, 0); repeat (3) tick();
    do_reset();                               // reset in the middle of a count

    // Random stimulus.
    for (int i = 0; i < 1500; i++) begin
      enable   = ($urandom_range(0, 9) != 0);
      flip     = ($urandom_range(0, 9) == 0);
      load     = ($urandom_range(0, 19) == 0);
      load_val = WIDTH'($urandom);
      step     = STEP_W'($urandom);
      if ($urandom_range(0, 7) == 0) mode = 2'($urandom);
      if ($urandom_range(0, 29) == 0) begin
        min = WIDTH'($urandom_range(0, 12));
        max = WIDTH'($urandom_range(0, 15));
      end
      if ($urandom_range(0, 199) == 0) do_reset();
      else tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
